// File: rtl/fir_lpf_pkg.sv
// Shared constants and helpers for the low-pass FIR datapath and its sequencer.
package fir_lpf_pkg;

  localparam int unsigned N_TAPS  = 36;
  localparam int unsigned N_DSP   = 6;
  localparam int unsigned MAC_LAT = 3;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned x = 1; x < v; x = x << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/fir_tdm_sequencer_strobe_delay.sv
// Clock-enabled shift register carrying strobes alongside the MAC pipeline.
module strobe_delay #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 3
) (
  input  logic             clk,
  input  logic             sclr_n,
  input  logic             ce,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift on ce; synchronous clear wins over ce, async reset over both.
  always_ff @(posedge clk or negedge sclr_n) begin
    if (!sclr_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (ce) begin
      stage[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/fir_tdm_sequencer.sv
// Time-division scheduler for the shared-DSP FIR: phase counter, issue
// register, MAC-aligned accumulator strobes, output load and frame counter.
module fir_tdm_sequencer
  import fir_lpf_pkg::*;
#(
  parameter int unsigned N_TAPS  = fir_lpf_pkg::N_TAPS,
  parameter int unsigned N_DSP   = fir_lpf_pkg::N_DSP,
  parameter int unsigned MAC_LAT = fir_lpf_pkg::MAC_LAT,
  localparam int unsigned PHASES = N_TAPS / N_DSP,
  localparam int unsigned PH_W   = clog2(PHASES),
  localparam int unsigned TAP_W  = clog2(N_TAPS)
) (
  input  logic             clk,
  input  logic             sclr_n,
  input  logic             ce,
  input  logic             sync,
  output logic             sample_clk,
  output logic             din_load,
  output logic [PH_W-1:0]  phase,
  output logic [TAP_W-1:0] tap_base,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             dout_load,
  output logic [15:0]      frame_cnt
);

  localparam int unsigned      CNT_W    = clog2(PHASES + 1);
  localparam logic [PH_W-1:0]  P_LAST   = PH_W'(PHASES - 1);
  localparam logic [PH_W-1:0]  P_HALF   = PH_W'(PHASES / 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PHASES);

  logic [PH_W-1:0]  p;
  logic             issue_vld;
  logic [1:0]       dly_q;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] acc_cnt_nxt;
  logic             frame_done;

  // Phase counter and registered issue outputs.
  always_ff @(posedge clk or negedge sclr_n) begin
    if (!sclr_n) begin
      p          <= '0;
      issue_vld  <= 1'b0;
      phase      <= '0;
      tap_base   <= '0;
      din_load   <= 1'b0;
      sample_clk <= 1'b0;
    end else if (sync) begin
      p          <= '0;
      issue_vld  <= 1'b0;
      phase      <= '0;
      tap_base   <= '0;
      din_load   <= 1'b0;
      sample_clk <= 1'b0;
    end else if (ce) begin
      p          <= (p == P_LAST) ? '0 : p + 1'b1;
      issue_vld  <= 1'b1;
      phase      <= p;
      tap_base   <= TAP_W'(32'(p) * N_DSP);
      din_load   <= (p == '0);
      sample_clk <= (p < P_HALF);
    end
  end

  // Issue-valid and issue-first travel with the MAC pipeline.
  strobe_delay #(
    .WIDTH (2),
    .DEPTH (MAC_LAT)
  ) u_strobe_delay (
    .clk    (clk),
    .sclr_n (sclr_n),
    .ce     (ce),
    .clr    (sync),
    .d      ({issue_vld, issue_vld & din_load}),
    .q      (dly_q)
  );

  assign acc_en  = dly_q[1];
  assign acc_clr = dly_q[0];

  // Count products accumulated in the current frame; the frame is complete
  // when the product in flight brings the count to PHASES. Restarting on
  // acc_clr means a sync-truncated frame can never reach the full count.
  always_comb begin
    acc_cnt_nxt = acc_clr ? CNT_W'(1) : acc_cnt + 1'b1;
    frame_done  = acc_en && (acc_cnt_nxt == CNT_FULL);
  end

  // Product counter and output-load strobe.
  always_ff @(posedge clk or negedge sclr_n) begin
    if (!sclr_n) begin
      acc_cnt   <= '0;
      dout_load <= 1'b0;
    end else if (sync) begin
      acc_cnt   <= '0;
      dout_load <= 1'b0;
    end else if (ce) begin
      dout_load <= frame_done;
      if (acc_en) acc_cnt <= acc_cnt_nxt;
    end
  end

  // Completed-frame counter; holds through sync.
  always_ff @(posedge clk or negedge sclr_n) begin
    if (!sclr_n) begin
      frame_cnt <= '0;
    end else if (!sync && ce && frame_done) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fir_tdm_sequencer.sv
// Bench for fir_tdm_sequencer: three parameterisations share one stimulus
// stream and are checked each edge against an edge-count reference model.
module tb_fir_tdm_sequencer;
  import fir_lpf_pkg::*;

  localparam int unsigned PW0 = clog2(36 / 6);
  localparam int unsigned TW0 = clog2(36);
  localparam int unsigned PWA = clog2(12 / 6);
  localparam int unsigned TWA = clog2(12);
  localparam int unsigned PWB = clog2(36 / 4);
  localparam int unsigned TWB = clog2(36);

  logic clk, sclr_n, ce, sync;

  logic           sclk0, dl0, aclr0, aen0, dout0;
  logic [PW0-1:0] ph0;
  logic [TW0-1:0] tb0;
  logic [15:0]    fc0;

  logic           sclkA, dlA, aclrA, aenA, doutA;
  logic [PWA-1:0] phA;
  logic [TWA-1:0] tbA;
  logic [15:0]    fcA;

  logic           sclkB, dlB, aclrB, aenB, doutB;
  logic [PWB-1:0] phB;
  logic [TWB-1:0] tbB;
  logic [15:0]    fcB;

  fir_tdm_sequencer u0 (
    .clk(clk), .sclr_n(sclr_n), .ce(ce), .sync(sync),
    .sample_clk(sclk0), .din_load(dl0), .phase(ph0), .tap_base(tb0),
    .acc_clr(aclr0), .acc_en(aen0), .dout_load(dout0), .frame_cnt(fc0)
  );

  fir_tdm_sequencer #(.N_TAPS(12), .N_DSP(6), .MAC_LAT(1)) ua (
    .clk(clk), .sclr_n(sclr_n), .ce(ce), .sync(sync),
    .sample_clk(sclkA), .din_load(dlA), .phase(phA), .tap_base(tbA),
    .acc_clr(aclrA), .acc_en(aenA), .dout_load(doutA), .frame_cnt(fcA)
  );

  fir_tdm_sequencer #(.N_TAPS(36), .N_DSP(4), .MAC_LAT(5)) ub (
    .clk(clk), .sclr_n(sclr_n), .ce(ce), .sync(sync),
    .sample_clk(sclkB), .din_load(dlB), .phase(phB), .tap_base(tbB),
    .acc_clr(aclrB), .acc_en(aenB), .dout_load(doutB), .frame_cnt(fcB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    int   ph;
    int   tb;
    logic sclk;
    logic dl;
    logic aen;
    logic aclr;
    logic dout;
  } exp_t;

  int          n_chk;
  int          n_pass;
  int          k;            // ce=1 edges since reset/sync release
  logic [15:0] fexp [3];
  int          cfg_ph [3] = '{6, 2, 9};
  int          cfg_nd [3] = '{6, 6, 4};
  int          cfg_ml [3] = '{3, 1, 5};

  task automatic check_eq(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge count %0d)", tag, obs, exp_v, k);
  endtask

  // Expected outputs after the kk-th ce edge since release.
  function automatic exp_t model(input int kk, input int ph, input int nd, input int ml);
    exp_t e;
    int   pi;
    e = '0;
    if (kk > 0) begin
      pi     = (kk - 1) % ph;
      e.ph   = pi;
      e.tb   = pi * nd;
      e.dl   = (pi == 0);
      e.sclk = (pi < ph / 2);
      e.aen  = (kk > ml);
      e.aclr = e.aen && (((kk - ml - 1) % ph) == 0);
      e.dout = (kk >= ph + ml + 1) && (((kk - ph - ml - 1) % ph) == 0);
    end
    return e;
  endfunction

  task automatic check_cfg(input string nm, input int idx,
                           input int o_ph, input int o_tb, input logic o_sclk,
                           input logic o_dl, input logic o_aen, input logic o_aclr,
                           input logic o_dout, input logic [15:0] o_fc);
    exp_t e;
    e = model(k, cfg_ph[idx], cfg_nd[idx], cfg_ml[idx]);
    check_eq({nm, ".phase"},      o_ph,         e.ph);
    check_eq({nm, ".tap_base"},   o_tb,         e.tb);
    check_eq({nm, ".sample_clk"}, int'(o_sclk), int'(e.sclk));
    check_eq({nm, ".din_load"},   int'(o_dl),   int'(e.dl));
    check_eq({nm, ".acc_en"},     int'(o_aen),  int'(e.aen));
    check_eq({nm, ".acc_clr"},    int'(o_aclr), int'(e.aclr));
    check_eq({nm, ".dout_load"},  int'(o_dout), int'(e.dout));
    check_eq({nm, ".frame_cnt"},  int'(o_fc),   int'(fexp[idx]));
  endtask

  task automatic check_all();
    check_cfg("def", 0, int'(ph0), int'(tb0), sclk0, dl0, aen0, aclr0, dout0, fc0);
    check_cfg("swA", 1, int'(phA), int'(tbA), sclkA, dlA, aenA, aclrA, doutA, fcA);
    check_cfg("swB", 2, int'(phB), int'(tbB), sclkB, dlB, aenB, aclrB, doutB, fcB);
  endtask

  // Apply ce/sync for one edge, advance the model, check #1 after the edge.
  task automatic tick(input logic c, input logic s);
    exp_t e;
    ce   = c;
    sync = s;
    @(posedge clk);
    if (s) k = 0;
    else if (c) begin
      k++;
      for (int i = 0; i < 3; i++) begin
        e = model(k, cfg_ph[i], cfg_nd[i], cfg_ml[i]);
        if (e.dout) fexp[i] = fexp[i] + 16'd1;
      end
    end
    #1;
    check_all();
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    k      = 0;
    for (int i = 0; i < 3; i++) fexp[i] = '0;
    sclr_n = 1'b0;
    ce     = 1'b0;
    sync   = 1'b0;

    #3 check_all();
    #4 sclr_n = 1'b1;

    // Continuous run from reset.
    repeat (20) tick(1'b1, 1'b0);

    // ce toggling every cycle.
    for (int i = 0; i < 40; i++) tick((i % 2) == 0, 1'b0);

    // Restart, then sync when issue phase 3 of frame 2 is showing.
    tick(1'b1, 1'b1);
    repeat (10) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    repeat (20) tick(1'b1, 1'b0);

    // Randomised ce and occasional sync.
    repeat (300) tick($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);

    // Asynchronous reset between edges, mid-frame.
    repeat (4) tick(1'b1, 1'b0);
    #2 sclr_n = 1'b0;
    #1;
    k = 0;
    for (int i = 0; i < 3; i++) fexp[i] = '0;
    check_all();
    #2 sclr_n = 1'b1;
    repeat (20) tick(1'b1, 1'b0);

    // Frame counter wrap on the default instance.
    tick(1'b0, 1'b0);
    force u0.frame_cnt = 16'hFFFE;
    #1;
    release u0.frame_cnt;
    fexp[0] = 16'hFFFE;
    repeat (14) tick(1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
